irq_controller_core: RTL

- Parametrised successor to the 8-line IRQ latch.
- Registers NUM_IRQ request lines in edge or level mode into an IRR, applies a mask, and resolves priority with fully nested in-service (ISR) tracking.
- Runs a two-pulse INTA acknowledge handshake that returns the serviced vector id, and supports specific and non-specific EOI.
- Sits between the external IR pins (already synchronised) and the PIC bus/control logic.

---
 rtl/irq_pkg.sv | 53 +++++
 rtl/irq_controller_core_prio_resolver.sv | 30 +++
 rtl/irq_controller_core.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared types and helpers for the IRQ controller core.
// prio_pick/prio_rank operate on a 32-bit envelope so one
// definition serves every NUM_IRQ in 2..32.
package irq_pkg;

    localparam int NUM_IRQ_DEFAULT = 8;
    localparam int MAX_IRQ         = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK1 = 1'b1
    } state_e;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } pick_t;

    // (a + b) mod n, with a, b < n <= 32
    function automatic logic [4:0] wrap_add(input logic [4:0] a, input logic [4:0] b, input int n);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'(n)) s = s - 6'(n);
        return s[4:0];
    endfunction

    // Position of idx in the priority order starting at base (0 = highest)
    function automatic logic [4:0] prio_rank(input logic [4:0] idx, input logic [4:0] base, input int n);
        logic [5:0] r;
        r = {1'b0, idx} + 6'(n) - {1'b0, base};
        if (r >= 6'(n)) r = r - 6'(n);
        return r[4:0];
    endfunction

    // Highest-priority set bit of vec, walking base, base+1, ... mod n.
    // Scanning from lowest to highest priority lets the best hit overwrite.
    function automatic pick_t prio_pick(input logic [MAX_IRQ-1:0] vec, input logic [4:0] base, input int n);
        pick_t      p;
        logic [4:0] idx;
        p = '0;
        for (int k = MAX_IRQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = wrap_add(base, 5'(k), n);
                if (vec[idx]) begin
                    p.found = 1'b1;
                    p.idx   = idx;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/irq_controller_core_prio_resolver.sv
// irq_prio_resolver: combinational rotate -> priority encode -> unrotate.
// Returns the highest-priority set bit of vec given the current top line.
module irq_prio_resolver
    import irq_pkg::*;
#(
    parameter int N    = NUM_IRQ_DEFAULT,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    vec,
    input  logic [ID_W-1:0] base,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    logic [MAX_IRQ-1:0] vec_ext;
    logic [4:0]         base_ext;
    pick_t              pick;

    // Widen to the package envelope, resolve, narrow back to an id
    always_comb begin
        vec_ext           = '0;
        vec_ext[N-1:0]    = vec;
        base_ext          = '0;
        base_ext[ID_W-1:0] = base;
        pick              = prio_pick(vec_ext, base_ext, N);
        found             = pick.found;
        idx               = ID_W'(pick.idx);
    end

endmodule

// File: rtl/irq_controller_core.sv
// irq_controller_core: IRR capture (edge/level), mask, fully nested
// priority against the ISR, two-pulse INTA handshake, specific and
// non-specific EOI.
// Optional macro IRQ_ROTATE_PRIO_EN: rotating priority via prio_base,
// which moves just past every line cleared by an EOI.
module irq_controller_core
    import irq_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEFAULT,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               level_mode,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               inta,
    input  logic               eoi,
    input  logic               eoi_specific,
    input  logic [ID_W-1:0]    eoi_id,
    output logic               int_out,
    output logic               vector_valid,
    output logic [ID_W-1:0]    vector_id,
    output logic [NUM_IRQ-1:0] irr,
    output logic [NUM_IRQ-1:0] isr
);

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d, prev_q, prev_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d, vid_q, vid_d;
    logic               int_q, int_d, vv_q, vv_d;
    logic [ID_W-1:0]    prio_base;
    logic [NUM_IRQ-1:0] eligible, ack_vec;
    logic               win_found, isr_found, ack_take, eoi_hit;
    logic [ID_W-1:0]    win_idx, isr_top, eoi_idx;

`ifdef IRQ_ROTATE_PRIO_EN
    logic [ID_W-1:0] prio_base_q, prio_base_d;
    assign prio_base = prio_base_q;
`else
    assign prio_base = '0;
`endif

    assign eligible = irr_q & ~mask;

    irq_prio_resolver #(.N(NUM_IRQ), .ID_W(ID_W)) u_win_res (
        .vec(eligible), .base(prio_base), .found(win_found), .idx(win_idx)
    );

    irq_prio_resolver #(.N(NUM_IRQ), .ID_W(ID_W)) u_isr_res (
        .vec(isr_q), .base(prio_base), .found(isr_found), .idx(isr_top)
    );

    // Next-state: handshake FSM, IRR/ISR updates, EOI and registered outputs
    always_comb begin
        state_d  = state_q;
        cur_id_d = cur_id_q;
        vv_d     = 1'b0;
        vid_d    = vid_q;
        prev_d   = irq_in;
        ack_take = (state_q == ST_IDLE) && inta && win_found;
        ack_vec  = '0;
        if (ack_take) ack_vec[win_idx] = 1'b1;

        // Edge mode keeps a latched edge only while the pin stays high
        if (level_mode) irr_d = irq_in;
        else            irr_d = (irr_q | (irq_in & ~prev_q)) & irq_in;
        irr_d = irr_d & ~ack_vec;

        // EOI decision is taken on the old ISR; the ack set lands afterwards
        eoi_hit = 1'b0;
        eoi_idx = '0;
        if (eoi) begin
            if (eoi_specific) begin
                if (int'(eoi_id) < NUM_IRQ && isr_q[eoi_id]) begin
                    eoi_hit = 1'b1;
                    eoi_idx = eoi_id;
                end
            end else if (isr_found) begin
                eoi_hit = 1'b1;
                eoi_idx = isr_top;
            end
        end
        isr_d = isr_q;
        if (eoi_hit) isr_d[eoi_idx] = 1'b0;
        isr_d = isr_d | ack_vec;

`ifdef IRQ_ROTATE_PRIO_EN
        prio_base_d = prio_base_q;
        if (eoi_hit && !ack_vec[eoi_idx])
            prio_base_d = ID_W'(wrap_add(5'(eoi_idx), 5'd1, NUM_IRQ));
`endif

        case (state_q)
            ST_IDLE: begin
                if (inta) begin
                    cur_id_d = win_found ? win_idx : ID_W'(NUM_IRQ - 1);
                    state_d  = ST_ACK1;
                end
            end
            ST_ACK1: begin
                if (inta) begin
                    vv_d    = 1'b1;
                    vid_d   = cur_id_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Request only when the winner outranks everything in service
        int_d = (state_q == ST_IDLE) && !inta && win_found &&
                (!isr_found ||
                 prio_rank(5'(win_idx), 5'(prio_base), NUM_IRQ) <
                 prio_rank(5'(isr_top), 5'(prio_base), NUM_IRQ));
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            irr_q    <= '0;
            isr_q    <= '0;
            prev_q   <= '1;
            cur_id_q <= '0;
            int_q    <= 1'b0;
            vv_q     <= 1'b0;
            vid_q    <= '0;
`ifdef IRQ_ROTATE_PRIO_EN
            prio_base_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            irr_q    <= irr_d;
            isr_q    <= isr_d;
            prev_q   <= prev_d;
            cur_id_q <= cur_id_d;
            int_q    <= int_d;
            vv_q     <= vv_d;
            vid_q    <= vid_d;
`ifdef IRQ_ROTATE_PRIO_EN
            prio_base_q <= prio_base_d;
`endif
        end
    end

    assign int_out      = int_q;
    assign vector_valid = vv_q;
    assign vector_id    = vid_q;
    assign irr          = irr_q;
    assign isr          = isr_q;

endmodule
